// File: rtl/memory_pkg.sv
// Shared types and constants for the delay-line tap reader.
// Holds FSM encoding, Q-format and saturation limits.
package memory_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    MULT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int DEF_TIMEOUT   = 255;
  localparam int DEF_GAIN_FRAC = 8;

  localparam logic [15:0] SAT_MAX = 16'h7FFF;
  localparam logic [15:0] SAT_MIN = 16'h8000;

  localparam logic signed [31:0] LIM_HI = 32'sd32767;
  localparam logic signed [31:0] LIM_LO = -32'sd32768;

  // Drop fraction bits (floor) and clamp to signed 16-bit.
  function automatic logic [15:0] scale_sat(
    input logic signed [31:0] p,
    input int                 frac
  );
    logic signed [31:0] s;
    s = p >>> frac;
    if (s > LIM_HI)
      return SAT_MAX;
    else if (s < LIM_LO)
      return SAT_MIN;
    else
      return s[15:0];
  endfunction

endpackage

// File: rtl/shift_add_mult.sv
// Sequential signed x unsigned 16-bit multiplier.
// One multiplier bit per cycle, 16 cycles from start.
module shift_add_mult
  import memory_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [15:0]        a,
  input  logic [15:0]        b,
  output logic               done,
  output logic signed [31:0] product
);

  logic        running;
  logic [3:0]  cnt;
  logic [31:0] acc;
  logic [31:0] mcand;
  logic [15:0] mplier;

  // Load operands on start, then add/shift one bit per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      running <= 1'b0;
      cnt     <= 4'd0;
      acc     <= 32'd0;
      mcand   <= 32'd0;
      mplier  <= 16'd0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= 4'd0;
      acc     <= 32'd0;
      mcand   <= {{16{a[15]}}, a};
      mplier  <= b;
    end else if (running) begin
      if (mplier[0])
        acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 4'd1;
      if (cnt == 4'd15)
        running <= 1'b0;
    end
  end

  // done flags the last iteration; product is final after it.
  assign done    = running && (cnt == 4'd15);
  assign product = acc;

endmodule

// File: rtl/delay_tap_reader.sv
// Reads one delayed tap per sample strobe and applies a Q8.8 gain.
// Handles memory handshake timeout and overrun reporting.
module delay_tap_reader
  import memory_pkg::*;
#(
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int GAIN_FRAC = DEF_GAIN_FRAC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adc_clock,
  input  logic [15:0] write_addr,
  input  logic [15:0] delay_reverb,
  input  logic [15:0] gain,
  input  logic        mem_ready,
  input  logic [15:0] mem_data,
  output logic        memory_re,
  output logic [15:0] address_out,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        busy,
  output logic        overrun,
  output logic        rd_timeout
);

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t             state;
  state_t             state_n;
  logic               adc_q;
  logic               strobe;
  logic [15:0]        gain_q;
  logic               zero_tap;
  logic [15:0]        wait_cnt;
  logic               tmo;
  logic               mult_start;
  logic [15:0]        mult_a;
  logic               mult_done;
  logic signed [31:0] product;

  assign strobe    = adc_clock && !adc_q;
  assign memory_re = (state == ISSUE);
  assign busy      = (state != IDLE);

  shift_add_mult u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mult_start),
    .a       (mult_a),
    .b       (gain_q),
    .done    (mult_done),
    .product (product)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Next state, multiplier kick-off and operand select.
  always_comb begin
    state_n    = state;
    tmo        = 1'b0;
    mult_start = 1'b0;
    mult_a     = 16'h0000;
    unique case (state)
      IDLE: begin
        if (strobe)
          state_n = (delay_reverb == 16'h0000) ? OUT : ISSUE;
      end
      ISSUE: begin
        if (mem_ready) begin
          mult_start = 1'b1;
          mult_a     = mem_data;
          state_n    = MULT;
        end else if (wait_cnt == WAIT_LAST) begin
          tmo        = 1'b1;
          mult_start = 1'b1;
          state_n    = MULT;
        end
      end
      MULT: begin
        if (mult_done)
          state_n = OUT;
      end
      OUT: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Edge history, request latching, flags and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      adc_q       <= 1'b0;
      address_out <= 16'h0000;
      gain_q      <= 16'h0000;
      zero_tap    <= 1'b0;
      wait_cnt    <= 16'h0000;
      data_out    <= 16'h0000;
      data_valid  <= 1'b0;
      overrun     <= 1'b0;
      rd_timeout  <= 1'b0;
    end else begin
      adc_q      <= adc_clock;
      data_valid <= 1'b0;
      if (strobe && state != IDLE)
        overrun <= 1'b1;
      if (state == IDLE && strobe) begin
        address_out <= write_addr - delay_reverb;
        gain_q      <= gain;
        zero_tap    <= (delay_reverb == 16'h0000);
      end
      if (state == ISSUE)
        wait_cnt <= wait_cnt + 16'd1;
      else
        wait_cnt <= 16'h0000;
      if (tmo)
        rd_timeout <= 1'b1;
      if (state == OUT) begin
        data_out   <= zero_tap ? 16'h0000
                               : scale_sat(product, GAIN_FRAC);
        data_valid <= 1'b1;
      end
    end
  end

endmodule
